// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin scheduler sharing one 4:1 mux among four requesters,
// with registered selects/grant and a per-grant beat limit of MAX_HOLD.
module mux4_rr_sched #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    gnt,
  output logic          s1,
  output logic          s0,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, nxt, pick;
  logic [3:0] gnt_q, gnt_d, hold_q, hold_d;
  logic       xfer, rel;
  // Lowest offset from p wins, so iterate from the farthest offset down.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    rr_pick = p;
    for (int i = 3; i >= 0; i--)
      if (r[p + 2'(i)]) rr_pick = p + 2'(i);
  endfunction
  assign nxt        = sel_q + 2'd1;
  assign pick       = rr_pick(state_q == IDLE ? ptr_q : nxt, req);
  assign gnt        = gnt_q;
  assign {s1, s0}   = sel_q;
  assign dout       = sel_q == 2'd0 ? a : sel_q == 2'd1 ? b : sel_q == 2'd2 ? c : d;
  assign dout_valid = |gnt_q & req[sel_q];
  assign xfer       = dout_valid & dout_ready;
  assign rel        = ~req[sel_q] | (xfer & hold_q == 4'(MAX_HOLD - 1));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        sel_d   = pick;
        gnt_d   = 4'b1 << pick;
        hold_d  = '0;
      end
    end else if (rel) begin
      // Re-arbitrate on the release edge itself; selects freeze when going idle.
      ptr_d   = nxt;
      hold_d  = '0;
      state_d = |req ? GRANT : IDLE;
      sel_d   = |req ? pick : sel_q;
      gnt_d   = |req ? 4'b1 << pick : 4'b0;
    end else if (xfer) begin
      hold_d  = hold_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb_mux4_rr_sched: directed scenarios plus randomized traffic against a beat-counting
// round-robin reference model, for MAX_HOLD=4 and MAX_HOLD=2 instances.
module tb_mux4_rr_sched;
  logic       clk = 0, rst_n = 1, dout_ready = 0;
  logic [3:0] req = 0;
  logic [7:0] a = 0, b = 0, c = 0, d = 0;
  logic [3:0] gnt4, gnt2;
  logic       s1_4, s0_4, s1_2, s0_2, dv4, dv2;
  logic [7:0] dout4, dout2;
  int checks = 0, errors = 0;
  int m_own[2], m_cnt[2], m_ptr[2], m_sel[2];
  int mh[2] = '{4, 2};
  always #5 clk = ~clk;
  mux4_rr_sched #(.DW(8), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt4), .s1(s1_4), .s0(s0_4), .dout(dout4), .dout_valid(dv4), .dout_ready(dout_ready));
  mux4_rr_sched #(.DW(8), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt2), .s1(s1_2), .s0(s0_2), .dout(dout2), .dout_valid(dv2), .dout_ready(dout_ready));
  function automatic logic [7:0] data_of(input int i);
    return i == 0 ? a : i == 1 ? b : i == 2 ? c : d;
  endfunction
  function automatic int first_req(input int p);
    for (int i = 0; i < 4; i++) if (req[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_cnt[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
    end
  endtask
  // Owner keeps the mux until it stops requesting or has moved mh beats.
  task automatic upd();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_own[k] < 0) begin
        m_own[k] = first_req(m_ptr[k]);
        m_cnt[k] = 0;
      end else begin
        if (req[m_own[k]] && dout_ready) m_cnt[k]++;
        if (!req[m_own[k]] || m_cnt[k] == mh[k]) begin
          m_ptr[k] = (m_own[k] + 1) % 4;
          m_own[k] = first_req(m_ptr[k]);
          m_cnt[k] = 0;
        end
      end
      if (m_own[k] >= 0) m_sel[k] = m_own[k];
    end
  endtask
  task automatic cyc();
    upd();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [3:0] r);
    req = r;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  task automatic test_reset();
    model_reset();
    #2;
    req = 4'b1111; a = 8'h5A; dout_ready = 1;
    rst_n = 0;
    #1;
    checks++; if (gnt4 !== 4'b0 || gnt2 !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b/%b want 0000", gnt4, gnt2); end
    checks++; if ({s1_4, s0_4} !== 2'b00 || dv4 !== 1'b0) begin errors++; $display("FAIL reset_sel_valid: sel=%b dv=%b want 00/0", {s1_4, s0_4}, dv4); end
    checks++; if (dout4 !== 8'h5A) begin errors++; $display("FAIL reset_dout: got %h want 5a", dout4); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (gnt4 !== 4'b0 || dv4 !== 1'b0 || gnt2 !== 4'b0) begin errors++; $display("FAIL reset_hold: gnt=%b dv=%b want 0000/0", gnt4, dv4); end
    end
    rst_n = 1;
    cyc();
    checks++; if (gnt4 !== 4'b0001 || gnt2 !== 4'b0001) begin errors++; $display("FAIL reset_first_pick: got %b/%b want 0001", gnt4, gnt2); end
  endtask
  task automatic test_single();
    do_reset(4'b0000);
    req = 4'b0100; c = 8'h3C; dout_ready = 1;
    cyc();
    checks++; if (gnt4 !== 4'b0100 || {s1_4, s0_4} !== 2'b10) begin errors++; $display("FAIL single_grant: gnt=%b sel=%b want 0100/10", gnt4, {s1_4, s0_4}); end
    checks++; if (dout4 !== 8'h3C || dv4 !== 1'b1) begin errors++; $display("FAIL single_data: dout=%h dv=%b want 3c/1", dout4, dv4); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (gnt4 !== 4'b0100 || dv4 !== 1'b1) begin errors++; $display("FAIL single_regrant%0d: gnt=%b dv=%b want 0100/1", i, gnt4, dv4); end
      checks++; if (dut4.hold_q !== 4'(i % 4)) begin errors++; $display("FAIL single_hold%0d: got %0d want %0d", i, dut4.hold_q, i % 4); end
    end
  endtask
  task automatic test_round_robin();
    do_reset(4'b0000);
    req = 4'b1111; dout_ready = 1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      checks++;
      if (gnt2 !== 4'(1 << ((i / 2) % 4)) || {s1_2, s0_2} !== 2'((i / 2) % 4)) begin
        errors++; $display("FAIL rr_step%0d: gnt=%b sel=%b want owner %0d", i, gnt2, {s1_2, s0_2}, (i / 2) % 4);
      end
    end
  endtask
  task automatic test_back_pressure();
    do_reset(4'b0000);
    req = 4'b1110; dout_ready = 1;
    cyc();
    checks++; if (gnt4 !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", gnt4); end
    dout_ready = 0;
    repeat (5) begin
      cyc();
      checks++; if (gnt4 !== 4'b0010 || dut4.hold_q !== 4'd0) begin errors++; $display("FAIL bp_stall: gnt=%b hold=%0d want 0010/0", gnt4, dut4.hold_q); end
    end
    dout_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (gnt4 !== (i < 4 ? 4'b0010 : 4'b0100)) begin errors++; $display("FAIL bp_beat%0d: got %b want %b", i, gnt4, i < 4 ? 4'b0010 : 4'b0100); end
    end
  endtask
  task automatic test_early_drop();
    do_reset(4'b0000);
    req = 4'b0101; dout_ready = 1;
    cyc();
    cyc();
    checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL drop_owner: got %b want 0001", gnt4); end
    req = 4'b0100;
    #1;
    checks++; if (dv4 !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", dv4); end
    cyc();
    checks++; if (gnt4 !== 4'b0100 || dut4.ptr_q !== 2'd1) begin errors++; $display("FAIL drop_next: gnt=%b ptr=%0d want 0100/1", gnt4, dut4.ptr_q); end
    req = 4'b0000;
    cyc();
    checks++; if (gnt4 !== 4'b0 || dv4 !== 1'b0 || {s1_4, s0_4} !== 2'b10) begin errors++; $display("FAIL drop_idle: gnt=%b dv=%b sel=%b want 0000/0/10", gnt4, dv4, {s1_4, s0_4}); end
  endtask
  task automatic test_expiry_drop();
    do_reset(4'b0000);
    req = 4'b1001; dout_ready = 1;
    repeat (4) cyc();
    checks++; if (gnt4 !== 4'b0001 || dut4.hold_q !== 4'd3) begin errors++; $display("FAIL exp_last: gnt=%b hold=%0d want 0001/3", gnt4, dut4.hold_q); end
    cyc();
    req = 4'b1000;
    #1;
    checks++; if (gnt4 !== 4'b1000 || dut4.hold_q !== 4'd0 || dv4 !== 1'b1) begin errors++; $display("FAIL exp_next: gnt=%b hold=%0d dv=%b want 1000/0/1", gnt4, dut4.hold_q, dv4); end
  endtask
  task automatic test_random();
    logic [3:0] g;
    logic [1:0] s;
    logic [7:0] o;
    logic       v;
    int         eg;
    do_reset(4'b0000);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      dout_ready = $urandom_range(0, 3) != 0;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        g = k ? gnt2 : gnt4;
        s = k ? {s1_2, s0_2} : {s1_4, s0_4};
        o = k ? dout2 : dout4;
        v = k ? dv2 : dv4;
        eg = m_own[k] < 0 ? 0 : 1 << m_own[k];
        checks++;
        if (g !== 4'(eg) || s !== 2'(m_sel[k]) || o !== data_of(m_sel[k]) || v !== (m_own[k] >= 0 && req[m_own[k]])) begin
          errors++; $display("FAIL rand[%0d] cyc%0d: gnt=%b sel=%0d dout=%h dv=%b want %b/%0d/%h", k, n, g, s, o, v, 4'(eg), m_sel[k], data_of(m_sel[k]));
        end
      end
      cyc();
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_early_drop();
    test_expiry_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
